vga_result_ctrl: RTL

VGA_RESULT_CTRL -- requirements
Module: vga_result_ctrl

---
 rtl/vga_result_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_result_ctrl.sv
// Result overlay controller: CPU-set ODD/EVEN code, shown on the VGA renderer
// and applied only at the start of vertical blank, with optional blink and auto-clear.
module vga_result_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int unsigned HOLD_FRAMES  = 180,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [1:0]  result,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;

  localparam logic [9:0] HOLD_LAST  = 10'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  shown_q, shown_d;
  logic [1:0]  pend_code_q, pend_code_d;
  logic        pending_q, pending_d;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [1:0]  result_q, result_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit;
  logic        sel_cmd;
  logic        sel_stat;
  logic        sel_ctrl;
  logic        cmd_wr;
  logic        ctrl_wr;
  logic        frame_tick;
  logic        hold_run;
  logic [31:0] status;
  logic        unused_ok;

  assign hit      = bus_addr[31:4] == BASE_ADDR[31:4];
  assign sel_cmd  = hit && (bus_addr[3:0] == 4'h0);
  assign sel_stat = hit && (bus_addr[3:0] == 4'h4);
  assign sel_ctrl = hit && (bus_addr[3:0] == 4'h8);

  // Code 3 is reserved; such a write must leave everything untouched.
  assign cmd_wr  = bus_we && sel_cmd && (bus_wdata[1:0] != 2'b11);
  assign ctrl_wr = bus_we && sel_ctrl;

  assign frame_tick = (pixel_x == 10'd0) && (pixel_y == 10'd480);

  assign hold_run = (state_q == S_SHOW) && ctrl_q[0];
  assign status   = {28'd0, hold_run, shown_q, pending_q};

  assign unused_ok = ^bus_wdata[31:2];

  always_comb begin
    state_d     = state_q;
    shown_d     = shown_q;
    pend_code_d = pend_code_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    ctrl_d      = ctrl_q;

    if (ctrl_wr) begin
      ctrl_d = bus_wdata[1:0];
    end

    // A fresh command beats a coincident tick; it waits for the next one.
    if (cmd_wr) begin
      pend_code_d = bus_wdata[1:0];
      pending_d   = 1'b1;
      state_d     = S_WAIT;
    end else if (frame_tick) begin
      unique case (state_q)
        S_WAIT: begin
          shown_d   = pend_code_q;
          pending_d = 1'b0;
          if (pend_code_q != 2'b00) begin
            state_d     = S_SHOW;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHOW: begin
          if (ctrl_q[1]) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 8'd1;
            end
          end
          if (ctrl_q[0]) begin
            if (frame_cnt_q == HOLD_LAST) begin
              shown_d = 2'b00;
              state_d = S_IDLE;
            end else begin
              frame_cnt_d = frame_cnt_q + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result_d = shown_d;
    if (ctrl_d[1] && !phase_d) begin
      result_d = 2'b00;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (bus_re) begin
      unique case (1'b1)
        sel_stat: rdata_d = status;
        sel_ctrl: rdata_d = {30'd0, ctrl_q};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shown_q     <= 2'b00;
      pend_code_q <= 2'b00;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      ctrl_q      <= 2'b01;
      result_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      shown_q     <= shown_d;
      pend_code_q <= pend_code_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      rdata_q     <= rdata_d;
    end
  end

  assign result    = result_q;
  assign busy      = pending_q;
  assign bus_rdata = rdata_q;

endmodule
